// File: rtl/conv_pkg.sv
// Shared defaults and FSM state type for the convolution datapath
// (product streamer and accumulator stage).
package conv_pkg;

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_COEF_W = 5;
  localparam int DEF_TAPS   = 9;
  localparam int DEF_PROD_W = DEF_PIX_W + DEF_COEF_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/tap_mult.sv
// Combinational multiply of an unsigned pixel by a signed coefficient.
// Result is full precision; PROD_W always holds the exact product.
module tap_mult #(
  parameter  int PIX_W  = 8,
  parameter  int COEF_W = 5,
  localparam int PROD_W = PIX_W + COEF_W + 1
) (
  input  logic        [PIX_W-1:0]  pix,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [PROD_W-1:0] prod
);

  logic signed [PROD_W-1:0] pix_ext;
  logic signed [PROD_W-1:0] coef_ext;

  // Pixel is zero-extended (unsigned), coefficient sign-extended.
  assign pix_ext  = $signed(PROD_W'(pix));
  assign coef_ext = PROD_W'(coef);
  assign prod     = pix_ext * coef_ext;

endmodule

// File: rtl/kernel_product_streamer.sv
// Captures a pixel window plus kernel coefficients and streams one tap product
// per accepted beat. Define CONV_OVERLAP_EN for back-to-back windows.
module kernel_product_streamer
  import conv_pkg::*;
#(
  parameter  int PIX_W  = DEF_PIX_W,
  parameter  int COEF_W = DEF_COEF_W,
  parameter  int TAPS   = DEF_TAPS,
  localparam int PROD_W = PIX_W + COEF_W + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TAPS*PIX_W-1:0]     in_window,
  input  logic [TAPS*COEF_W-1:0]    in_coefs,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [PROD_W-1:0]  out_prod,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  state_t                    state_q, state_d;
  logic                      ready_en_q;
  logic [CNT_W-1:0]          tap_q;
  logic [TAPS*PIX_W-1:0]     win_q;
  logic [TAPS*COEF_W-1:0]    coef_q;
  logic signed [PROD_W-1:0]  prod;
  logic                      capture;
  logic                      accept;

  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && (tap_q == LAST_TAP);
  assign accept    = out_valid && out_ready;
  assign capture   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // NOTE: defaults are assigned first so no path through the case leaves an
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ready_en_q;
        if (in_valid && ready_en_q) state_d = STREAM;
      end
      STREAM: begin
        if (accept && out_last) begin
`ifdef CONV_OVERLAP_EN
          in_ready = 1'b1;
          state_d  = in_valid ? STREAM : IDLE;
`else
          state_d  = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the window and coefficient buffers are plain flops, not a RAM, so
  // they are cleared on reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      coef_q <= '0;
      tap_q  <= '0;
    end else begin
      if (capture) begin
        win_q  <= in_window;
        coef_q <= in_coefs;
      end
      if (capture)     tap_q <= '0;
      else if (accept) tap_q <= out_last ? '0 : tap_q + 1'b1;
    end
  end

  tap_mult #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W)
  ) u_tap_mult (
    .pix  (win_q[tap_q*PIX_W +: PIX_W]),
    .coef (coef_q[tap_q*COEF_W +: COEF_W]),
    .prod (prod)
  );

  assign out_prod = out_valid ? prod : '0;

endmodule

// File: tb/tb_kernel_product_streamer.sv
// Randomized bench for kernel_product_streamer against a queue-of-products
// model; expectations follow CONV_OVERLAP_EN when it is defined.
module tb_kernel_product_streamer;
  import conv_pkg::*;

  localparam int PIX_W  = DEF_PIX_W;
  localparam int COEF_W = DEF_COEF_W;
  localparam int TAPS   = DEF_TAPS;
  localparam int PROD_W = DEF_PROD_W;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [TAPS*PIX_W-1:0]    in_window = '0;
  logic [TAPS*COEF_W-1:0]   in_coefs = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [PROD_W-1:0] out_prod;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready = 1'b0;

  always #5 clk = ~clk;

  kernel_product_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_window (in_window),
    .in_coefs  (in_coefs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_prod  (out_prod),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  typedef struct {
    int prod;
    bit last;
    int tap;
  } item_t;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    init_exp = 1'b0;
  bit    cap_prev = 1'b0;
  bit    last_prev = 1'b0;

  logic [TAPS*PIX_W-1:0]  win_a, win_b;
  logic [TAPS*COEF_W-1:0] cf_a, cf_b;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_prod(input logic [TAPS*PIX_W-1:0] w,
                                    input logic [TAPS*COEF_W-1:0] c, input int k);
    logic        [PIX_W-1:0]  p;
    logic signed [COEF_W-1:0] q;
    p = w[k*PIX_W +: PIX_W];
    q = c[k*COEF_W +: COEF_W];
    return int'(p) * int'(q);
  endfunction

  // One clock: drive at negedge, check settled outputs, update model, wait edge.
  task automatic cycle(input logic iv, input logic [TAPS*PIX_W-1:0] w,
                       input logic [TAPS*COEF_W-1:0] c, input logic ordy);
    bit exp_rdy, cap, acc;
    @(negedge clk);
    in_valid = iv; in_window = w; in_coefs = c; out_ready = ordy;
    #1;
    exp_rdy = init_exp && (exp_q.size() == 0
`ifdef CONV_OVERLAP_EN
              || (exp_q.size() == 1 && ordy)
`endif
              );
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (cap_prev) check("tap0_latency", out_valid, 1);
`ifndef CONV_OVERLAP_EN
    if (last_prev) check("idle_gap", out_valid, 0);
`endif
    if (exp_q.size() != 0) begin
      check($sformatf("prod_tap%0d", exp_q[0].tap), $signed(out_prod), exp_q[0].prod);
      check($sformatf("last_tap%0d", exp_q[0].tap), out_last, exp_q[0].last);
    end else begin
      check("idle_prod", $signed(out_prod), 0);
      check("idle_last", out_last, 0);
    end
    cap = iv && exp_rdy;
    acc = (exp_q.size() != 0) && ordy;
    last_prev = acc && exp_q[0].last;
    if (acc) void'(exp_q.pop_front());
    if (cap)
      for (int k = 0; k < TAPS; k++)
        exp_q.push_back('{prod: model_prod(w, c, k), last: (k == TAPS-1), tap: k});
    cap_prev = cap;
    @(posedge clk);
  endtask

  // Offer one window, then drain it with optional stall, random ready and junk pulses.
  task automatic run_window(input logic [TAPS*PIX_W-1:0] w,
                            input logic [TAPS*COEF_W-1:0] c,
                            input int stall_tap, input int stall_len,
                            input bit rand_ready, input bit pulse);
    int guard = 0;
    int stall_cnt = 0;
    int n_prod = 0;
    logic ordy, iv;
    do begin
      cycle(1'b1, w, c, 1'b1);
      guard++;
    end while (!cap_prev && guard < 50);
    if (!cap_prev) check("capture_timeout", 1, 0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      if (exp_q[0].tap == stall_tap && stall_cnt < stall_len) begin
        ordy = 1'b0;
        stall_cnt++;
      end else begin
        ordy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      iv = pulse && (exp_q.size() > 1) && $urandom_range(0, 1);
      if (ordy) n_prod++;
      cycle(iv, {TAPS*PIX_W/8{8'hA5}} ^ TAPS*PIX_W'($urandom),
            TAPS*COEF_W'($urandom), ordy);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 1, 0);
    check("products_per_window", n_prod, TAPS);
  endtask

  task automatic rand_window(output logic [TAPS*PIX_W-1:0] w,
                             output logic [TAPS*COEF_W-1:0] c);
    for (int k = 0; k < TAPS; k++) begin
      w[k*PIX_W +: PIX_W]   = PIX_W'($urandom);
      c[k*COEF_W +: COEF_W] = COEF_W'($urandom);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    init_exp = 1'b1;
  endtask

  initial begin
    int span, caps, guard;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prod", $signed(out_prod), 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    release_reset();

    // Pixels 1..9, unit coefficients.
    for (int k = 0; k < TAPS; k++) begin
      win_a[k*PIX_W +: PIX_W]   = PIX_W'(k + 1);
      cf_a[k*COEF_W +: COEF_W]  = COEF_W'(1);
    end
    run_window(win_a, cf_a, -1, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);

    // Extreme magnitudes on taps 0 and 1.
    rand_window(win_a, cf_a);
    win_a[0 +: PIX_W]      = 8'd255;
    win_a[PIX_W +: PIX_W]  = 8'd255;
    cf_a[0 +: COEF_W]      = 5'sd0 - 5'sd16;
    cf_a[COEF_W +: COEF_W] = 5'sd15;
    check("model_neg_extreme", model_prod(win_a, cf_a, 0), -4080);
    check("model_pos_extreme", model_prod(win_a, cf_a, 1), 3825);
    run_window(win_a, cf_a, -1, 0, 1'b0, 1'b0);

    // Four-cycle stall on tap 3.
    rand_window(win_a, cf_a);
    run_window(win_a, cf_a, 3, 4, 1'b0, 1'b0);

    // Junk in_valid pulses while streaming must not disturb the window.
    rand_window(win_a, cf_a);
    run_window(win_a, cf_a, -1, 0, 1'b0, 1'b1);

    // Reset while tap 5 is presented.
    rand_window(win_a, cf_a);
    guard = 0;
    do begin
      cycle(exp_q.size() == 0, win_a, cf_a, 1'b1);
      guard++;
    end while (!(exp_q.size() != 0 && exp_q[0].tap == 5) && guard < 40);
    check("reached_tap5", exp_q.size() != 0 && exp_q[0].tap == 5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_prod", $signed(out_prod), 0);
    check("async_rst_last", out_last, 0);
    check("async_rst_ready", in_ready, 0);
    exp_q.delete();
    init_exp = 1'b0; cap_prev = 1'b0; last_prev = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    repeat (6) cycle(1'b0, '0, '0, 1'b1);

    // Two windows with in_valid held high.
    rand_window(win_a, cf_a);
    rand_window(win_b, cf_b);
    guard = 0;
    do begin
      cycle(1'b1, win_a, cf_a, 1'b1);
      guard++;
    end while (!cap_prev && guard < 20);
    span = 0; caps = 1;
    do begin
      cycle(caps < 2, win_b, cf_b, 1'b1);
      span++;
      if (cap_prev) caps++;
    end while ((exp_q.size() != 0 || caps < 2) && span < 60);
`ifdef CONV_OVERLAP_EN
    check("b2b_span", span, 2 * TAPS);
`else
    check("b2b_span", span, 2 * TAPS + 1);
`endif

    // Random windows under random backpressure.
    for (int n = 0; n < 20; n++) begin
      rand_window(win_a, cf_a);
      run_window(win_a, cf_a, int'($urandom_range(0, TAPS)), int'($urandom_range(0, 3)),
                 1'b1, n[0]);
      if ($urandom_range(0, 1) != 0) cycle(1'b0, '0, '0, 1'b1);
    end
    repeat (3) cycle(1'b0, '0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/kernel_product_streamer.md
KERNEL_PRODUCT_STREAMER -- requirements
Module: kernel_product_streamer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, unsigned pixel width.
REQ-002 SHALL have parameter COEF_W, default 5, signed kernel coefficient width.
REQ-003 SHALL have parameter TAPS, default 9, number of window taps (3x3 kernel).
REQ-004 SHALL have derived localparam PROD_W = PIX_W+COEF_W+1 (default 14), equal to the accumulator input width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port in_window, input, TAPS*PIX_W, pixels; tap k at bits [k*PIX_W +: PIX_W].
REQ-008 SHALL have port in_coefs, input, TAPS*COEF_W, signed coefficients; tap k at [k*COEF_W +: COEF_W].
REQ-009 SHALL have port in_valid, input, 1, window plus coefficients present.
REQ-010 SHALL have port in_ready, output, 1, block can capture a window.
REQ-011 SHALL have port out_prod, output, PROD_W signed, one tap product.
REQ-012 SHALL have port out_valid, output, 1, out_prod valid; drives the accumulator's valid input.
REQ-013 SHALL have port out_last, output, 1, marks the final product of a window.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts out_prod.

Function
REQ-015 SHALL capture in_window and in_coefs into internal registers on the rising edge where in_valid && in_ready.
REQ-016 SHALL implement FSM IDLE -> STREAM on capture, and STREAM -> IDLE when the product with out_last is accepted (out_valid && out_ready).
REQ-017 SHALL drive in_ready=1 only in IDLE (see REQ-028 for the exception).
REQ-018 SHALL compute the product as signed({1'b0,pixel}) * coef, full PROD_W width, no truncation or saturation.
REQ-019 SHALL present the tap-0 product registered one cycle after capture; out_valid SHALL stay 1 through STREAM.
REQ-020 SHALL emit products in tap order 0..TAPS-1, using a tap counter that advances only on out_valid && out_ready.
REQ-021 SHALL hold out_prod, out_last and the tap counter stable while out_valid && !out_ready.
REQ-022 SHALL assert out_last only with tap TAPS-1; the counter SHALL return to 0 after that product is accepted.
REQ-023 SHALL ignore in_valid while in_ready=0, with no capture and no corruption of the buffered window.
REQ-024 SHALL drive out_prod=0 whenever out_valid=0.

Reset
REQ-025 While rst_n=0, SHALL force: state IDLE, tap counter 0, out_prod=0, out_valid=0, out_last=0, in_ready=0, and window/coef registers cleared.
REQ-026 SHALL set in_ready=1 on the first clock edge after rst_n deasserts.
REQ-027 On reset mid-window, SHALL discard the partial window; no further products from it.

Configuration
REQ-028 With macro CONV_OVERLAP_EN defined, SHALL assert in_ready in STREAM during the cycle the last product is accepted, allowing back-to-back windows with no idle cycle between the last tap of window N and tap 0 of window N+1.
REQ-029 Without CONV_OVERLAP_EN, SHALL follow each window by at least one IDLE cycle with out_valid=0 before tap 0 of the next window.

Structure
REQ-030 Package conv_pkg SHALL hold PIX_W, COEF_W, TAPS and PROD_W defaults, and the state enum type (IDLE, STREAM), shared with the accumulator stage.
REQ-031 SHALL contain one sub-module, tap_mult: a combinational signed multiply of an unsigned pixel by a signed coefficient into PROD_W bits.

Verification
REQ-032 Pixels 1..9, all coefs +1, out_ready=1 -> out_prod 1,2,...,9 on consecutive cycles starting one cycle after capture; out_last only with 9.
REQ-033 Pixel 255 with coef -16 on tap 0 and coef +15 on tap 1 -> out_prod -4080 then 3825; no overflow.
REQ-034 out_ready=0 for 4 cycles while tap 3 is presented -> out_prod and out_last frozen at tap 3; tap 4 follows after out_ready rises; exactly 9 products total.
REQ-035 rst_n=0 while tap 5 is presented -> all outputs 0 immediately (asynchronously); in_ready=1 after release; taps 6..8 never appear.
REQ-036 Two windows with in_valid held high -> with CONV_OVERLAP_EN, 18 contiguous valid products; without it, exactly one out_valid=0 gap between tap 8 and the next tap 0.
REQ-037 in_valid pulsed with different data during STREAM (in_ready=0) -> the current window's products are unchanged and the pulsed window is not captured.
